// File: rtl/axi_req_master.sv
// axi_req_master: executes 72-bit request beats as single AXI4-Lite writes/reads, returning read data on a stream.
module axi_req_master #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [71:0]           AXIS_REQ_TDATA,
  input  logic                  AXIS_REQ_TVALID,
  output logic                  AXIS_REQ_TREADY,
  output logic [63:0]           RSP_TDATA,
  output logic                  RSP_TVALID,
  input  logic                  RSP_TREADY,
  output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0]            M_AXI_AWPROT,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [31:0]           M_AXI_WDATA,
  output logic [3:0]            M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [31:0]           M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY,
  output logic [31:0]           write_count,
  output logic [31:0]           read_count,
  output logic [31:0]           error_count,
  output logic                  busy
);
  typedef enum logic [2:0] {IDLE, WRITE, WR_RESP, RD_ADDR, RD_DATA, RSP_OUT} state_t;
  state_t state, state_nx;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic aw_done, w_done;
  logic req_hs, aw_hs, w_hs, b_hs, r_hs, bad_op, err_inc;
  logic [7:0] op;
  assign op = AXIS_REQ_TDATA[71:64];
  assign req_hs = AXIS_REQ_TVALID & AXIS_REQ_TREADY;
  assign bad_op = op > 8'd1;
  assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs = M_AXI_WVALID & M_AXI_WREADY;
  assign b_hs = M_AXI_BVALID & M_AXI_BREADY;
  assign r_hs = M_AXI_RVALID & M_AXI_RREADY;
  assign err_inc = (req_hs & bad_op) | (b_hs & |M_AXI_BRESP) | (r_hs & |M_AXI_RRESP);
  function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic inc);
    return c + {31'd0, inc & ~&c};
  endfunction
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_hs) state_nx = op == 8'd0 ? WRITE : op == 8'd1 ? RD_ADDR : IDLE;
      WRITE:   if ((aw_done | aw_hs) & (w_done | w_hs)) state_nx = WR_RESP;
      WR_RESP: if (M_AXI_BVALID) state_nx = IDLE;
      RD_ADDR: if (M_AXI_ARREADY) state_nx = RD_DATA;
      RD_DATA: if (M_AXI_RVALID) state_nx = RSP_OUT;
      RSP_OUT: if (RSP_TREADY) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    AXIS_REQ_TREADY = state == IDLE;
    busy = state != IDLE;
    M_AXI_AWVALID = state == WRITE && !aw_done;
    M_AXI_WVALID = state == WRITE && !w_done;
    M_AXI_BREADY = state == WR_RESP;
    M_AXI_ARVALID = state == RD_ADDR;
    M_AXI_RREADY = state == RD_DATA;
    RSP_TVALID = state == RSP_OUT;
    M_AXI_AWADDR = addr_q[ADDR_WIDTH-1:0];
    M_AXI_ARADDR = addr_q[ADDR_WIDTH-1:0];
    M_AXI_WDATA = wdata_q;
    M_AXI_WSTRB = 4'hF;
    M_AXI_AWPROT = 3'd0;
    M_AXI_ARPROT = 3'd0;
    RSP_TDATA = {addr_q, rdata_q};
  end
  // Done flags only survive while staying in WRITE, so each new write starts clean.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      write_count <= '0;
      read_count <= '0;
      error_count <= '0;
    end else begin
      if (req_hs) begin
        addr_q <= AXIS_REQ_TDATA[63:32];
        wdata_q <= AXIS_REQ_TDATA[31:0];
      end
      if (r_hs) rdata_q <= M_AXI_RDATA;
      aw_done <= state_nx == WRITE && (aw_done | aw_hs);
      w_done <= state_nx == WRITE && (w_done | w_hs);
      write_count <= sat_inc(write_count, b_hs);
      read_count <= sat_inc(read_count, r_hs);
      error_count <= sat_inc(error_count, err_inc);
    end
  end
endmodule
